uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer_if.sv | 11 +
 rtl/uart_tx_serializer.sv | 109 ++++++++++
 tb/tb_uart_tx_serializer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Request/serial-line bundle between the character generator (master) and the
// 8N1 transmitter (slave).
interface uart_tx_serializer_if;
  logic       i_wr;
  logic [7:0] i_data;
  logic       o_uart_tx;
  logic       o_busy;

  modport master (output i_wr, i_data, input  o_uart_tx, o_busy);
  modport slave  (input  i_wr, i_data, output o_uart_tx, o_busy);
endinterface

// File: rtl/uart_tx_serializer.sv
// Byte-wide 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit,
// each held for CLOCKS_PER_BAUD cycles. Line and busy are both registered.
module uart_tx_serializer #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd1250
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  uart_tx_serializer_if.slave  tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [23:0] BAUD_LAST = CLOCKS_PER_BAUD - 24'd1;

  state_t      state, state_n;
  logic [23:0] baud_cnt, baud_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shift, shift_n;
  logic        line, line_n;
  logic        busy, busy_n;
  logic        wrap;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      baud_cnt <= 24'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'hFF;
      line     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      line     <= line_n;
      busy     <= busy_n;
    end
  end

  assign wrap = (baud_cnt == 24'd0);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    line_n  = line;
    busy_n  = busy;
    case (state)
      IDLE: begin
        line_n = 1'b1;
        busy_n = 1'b0;
        if (tx.i_wr && !busy) begin
          shift_n = tx.i_data;
          line_n  = 1'b0;
          busy_n  = 1'b1;
          baud_n  = BAUD_LAST;
          state_n = START;
        end
      end
      START: begin
        if (wrap) begin
          baud_n  = BAUD_LAST;
          bit_n   = 3'd0;
          line_n  = shift[0];
          state_n = DATA;
        end else begin
          baud_n = baud_cnt - 24'd1;
        end
      end
      DATA: begin
        if (wrap) begin
          baud_n  = BAUD_LAST;
          // shift[1] is the bit that lands in shift[0] on this same edge
          shift_n = {1'b1, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            line_n  = 1'b1;
            state_n = STOP;
          end else begin
            bit_n  = bit_cnt + 3'd1;
            line_n = shift[1];
          end
        end else begin
          baud_n = baud_cnt - 24'd1;
        end
      end
      STOP: begin
        line_n = 1'b1;
        if (wrap) begin
          baud_n  = BAUD_LAST;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          baud_n = baud_cnt - 24'd1;
        end
      end
      default: begin
        line_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign tx.o_uart_tx = line;
  assign tx.o_busy    = busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame tables, hand-written corner sequences and
// a randomized run against a cycle-level frame model (CPB=4), plus a CPB=1250 frame.
module tb_uart_tx_serializer;
  localparam int CPB   = 4;
  localparam int CPB_B = 1250;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  uart_tx_serializer_if bus_a ();
  uart_tx_serializer_if bus_b ();

  uart_tx_serializer #(.CLOCKS_PER_BAUD(24'd4)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .tx(bus_a)
  );
  uart_tx_serializer #(.CLOCKS_PER_BAUD(24'd1250)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .tx(bus_b)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // expected level per bit period, index 0 = start bit
  } vec_t;
  vec_t tbl[6];

  int checks = 0;
  int errors = 0;

  // frame model: a frame is the 10-level vector {stop, data, start}, each level CPB cycles
  bit         m_active = 1'b0;
  int         m_el = 0;
  logic [9:0] m_frame = 10'h3FF;

  bit tr[$];
  bit bz[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_a) m_active = 1'b0;
    else if (m_active) begin
      m_el++;
      if (m_el == 10 * CPB) m_active = 1'b0;
    end else if (bus_a.i_wr) begin
      m_active = 1'b1;
      m_el     = 0;
      m_frame  = {1'b1, bus_a.i_data, 1'b0};
    end
    #1;
    chk("model_busy", bus_a.o_busy, m_active);
    chk("model_line", bus_a.o_uart_tx, m_active ? m_frame[m_el / CPB] : 1'b1);
    tr.push_back(bus_a.o_uart_tx);
    bz.push_back(bus_a.o_busy);
  endtask

  function automatic logic [7:0] decode(int s);
    logic [7:0] b;
    b = 8'h00;
    for (int j = 0; j < 8; j++) b[j] = tr[s + CPB * (1 + j) + CPB / 2];
    return b;
  endfunction

  task automatic send_check(vec_t v, string tag);
    int bad;
    bus_a.i_wr   = 1'b1;
    bus_a.i_data = v.data;
    step();
    bus_a.i_wr   = 1'b0;
    bus_a.i_data = 8'($urandom);
    bad = 0;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (bus_a.o_uart_tx !== v.line[k / CPB] || bus_a.o_busy !== 1'b1) bad++;
      step();
    end
    chk({tag, "_frame"}, bad, 0);
    chk({tag, "_busy_end"}, bus_a.o_busy, 1'b0);
    chk({tag, "_line_end"}, bus_a.o_uart_tx, 1'b1);
    step();
  endtask

  initial begin
    int bad, n;
    int st[$];
    logic [7:0] rx;
    int bcnt;

    tbl[0] = '{8'h48, 10'b1_0100_1000_0};
    tbl[1] = '{8'h65, 10'b1_0110_0101_0};
    tbl[2] = '{8'h00, 10'b1_0000_0000_0};
    tbl[3] = '{8'hFF, 10'b1_1111_1111_0};
    tbl[4] = '{8'hC3, 10'b1_1100_0011_0};
    tbl[5] = '{8'h55, 10'b1_0101_0101_0};

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.i_wr = 1'b0; bus_a.i_data = 8'h00;
    bus_b.i_wr = 1'b0; bus_b.i_data = 8'h00;
    step(); step();
    chk("reset_line", bus_a.o_uart_tx, 1'b1);
    chk("reset_busy", bus_a.o_busy, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;

    // idle for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus_a.o_uart_tx !== 1'b1 || bus_a.o_busy !== 1'b0) bad++;
    end
    chk("idle_100", bad, 0);

    foreach (tbl[i]) send_check(tbl[i], $sformatf("tbl%0d", i));

    // back-to-back "He" with request held high
    tr.delete(); bz.delete();
    bus_a.i_wr = 1'b1; bus_a.i_data = 8'h48;
    step();
    bus_a.i_data = 8'h65;
    for (n = 0; n < 120; n++) begin
      step();
      if (bus_a.i_wr && n > 2 && bz[bz.size()-1] && !bz[bz.size()-2]) bus_a.i_wr = 1'b0;
    end
    bus_a.i_wr = 1'b0;
    st.delete();
    foreach (bz[i]) if (bz[i] && (i == 0 || !bz[i-1])) st.push_back(i);
    chk("b2b_frames", st.size(), 2);
    if (st.size() == 2) begin
      chk("b2b_gap", st[1] - st[0], 41);
      chk("b2b_byte0", decode(st[0]), 8'h48);
      chk("b2b_byte1", decode(st[1]), 8'h65);
      bcnt = 0;
      for (int i = st[1] - 1; i >= 0 && tr[i]; i--) bcnt++;
      chk("b2b_high_time", bcnt, 5);
    end

    // data changed after accept is ignored
    tr.delete(); bz.delete();
    bus_a.i_wr = 1'b1; bus_a.i_data = 8'h55;
    step();
    bus_a.i_wr = 1'b0;
    step(); step();
    bus_a.i_data = 8'hAA;
    for (int i = 0; i < 45; i++) step();
    chk("late_data_byte", decode(0), 8'h55);

    // reset in the middle of data bit 3 of 0x00
    tr.delete(); bz.delete();
    bus_a.i_wr = 1'b1; bus_a.i_data = 8'h00;
    step();
    bus_a.i_wr = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("pre_rst_line", bus_a.o_uart_tx, 1'b0);
    chk("pre_rst_busy", bus_a.o_busy, 1'b1);
    #1 rst_a = 1'b1;
    #1;
    chk("async_rst_line", bus_a.o_uart_tx, 1'b1);
    chk("async_rst_busy", bus_a.o_busy, 1'b0);
    step(); step();
    rst_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus_a.o_uart_tx !== 1'b1 || bus_a.o_busy !== 1'b0) bad++;
    end
    chk("no_resume", bad, 0);
    send_check(tbl[4], "post_rst_c3");

    // randomized traffic against the frame model, with rare resets
    for (int i = 0; i < 3000; i++) begin
      bus_a.i_wr   = ($urandom_range(0, 2) == 0);
      bus_a.i_data = 8'($urandom);
      rst_a        = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_a = 1'b0; bus_a.i_wr = 1'b0;
    for (int i = 0; i < 45; i++) step();

    // full-rate frame at CPB=1250, sampled at mid-bit like a 9600 baud receiver
    bus_b.i_wr = 1'b1; bus_b.i_data = 8'h0D;
    step();
    bus_b.i_wr = 1'b0;
    bus_b.i_data = 8'hFF;
    rx = 8'h00; bcnt = 0; bad = 0;
    for (int k = 0; k < 13000; k++) begin
      if (bus_b.o_busy) bcnt++;
      if (k % CPB_B == CPB_B / 2) begin
        if (k / CPB_B == 0 && bus_b.o_uart_tx !== 1'b0) bad++;
        if (k / CPB_B == 9 && bus_b.o_uart_tx !== 1'b1) bad++;
        if (k / CPB_B >= 1 && k / CPB_B <= 8) rx[k / CPB_B - 1] = bus_b.o_uart_tx;
      end
      if (k >= 2 && k < 10 * CPB_B - 2 && k % 977 == 0) bus_b.i_wr = ~bus_b.i_wr;
      if (k >= 10 * CPB_B - 2) bus_b.i_wr = 1'b0;
      step();
    end
    chk("cpb1250_byte", rx, 8'h0D);
    chk("cpb1250_framing", bad, 0);
    chk("cpb1250_busy_len", bcnt, 12500);
    chk("cpb1250_idle_line", bus_b.o_uart_tx, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
